// File: rtl/fv_bank_req_gen.sv
// Feature-value bank request generator: write-back bursts and read requests toward one bank, read returns buffered and drained.
// Packets/drain lines are combinational from state; done/err are registered (one cycle later); cmd, wdata and rd stall via valid/ready, bank via bank_avail.
module fv_bank_req_gen #(
  parameter int FV_BW     = 128,
  parameter int MAX_LINES = 8,
  parameter int NODE_W    = 8,
  parameter int TAG_W     = 2,
  parameter int TMO       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd_wr,
  input  logic [NODE_W-1:0] cmd_node_id,
  input  logic [TAG_W-1:0]  cmd_pe_tag,
  input  logic [4:0]        cmd_fv_num,
  input  logic              wdata_valid,
  input  logic [FV_BW-1:0]  wdata,
  output logic              wdata_ready,
  input  logic              bank_avail,
  output logic              req_valid,
  output logic              req_rd_wr,
  output logic              req_wr_eos,
  output logic [NODE_W-1:0] req_node_id,
  output logic [TAG_W-1:0]  req_pe_tag,
  output logic [FV_BW-1:0]  req_data,
  input  logic              rsp_sos,
  input  logic              rsp_eos,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic [FV_BW-1:0]  rsp_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [FV_BW-1:0]  rd_data,
  output logic              rd_last,
  output logic              done,
  output logic [1:0]        err
);

  localparam int AW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [4:0] MAXL = 5'(MAX_LINES);

  typedef enum logic [2:0] {IDLE, LOAD, WR_ISSUE, RD_ISSUE, RD_WAIT, DRAIN} state_t;

  typedef struct packed {
    logic              rd_wr;
    logic [NODE_W-1:0] node_id;
    logic [TAG_W-1:0]  tag;
    logic [4:0]        lines;
  } cmd_t;

  state_t          state, state_nxt;
  cmd_t            lat, lat_nxt;
  logic [4:0]      idx, idx_nxt;
  logic [TW-1:0]   tmo_cnt, tmo_nxt;
  logic            strm, strm_nxt;
  logic            done_r, done_nxt;
  logic [1:0]      err_r, err_nxt;
  logic [FV_BW-1:0] line_buf [MAX_LINES];
  logic            buf_we;
  logic [AW-1:0]   buf_widx;
  logic [FV_BW-1:0] buf_wdat;
  logic [4:0]      cmd_lines, cap_idx;
  logic            last_idx, wr_go;

  assign cmd_lines = {1'b0, cmd_fv_num[4:1]} + {4'd0, cmd_fv_num[0]};
  assign last_idx  = (idx == lat.lines - 5'd1);
  // bank_avail only gates the first line; later lines stream unconditionally
  assign wr_go     = (state == WR_ISSUE) && ((idx != 5'd0) || bank_avail);
  assign cap_idx   = rsp_sos ? 5'd0 : idx;

  assign cmd_ready   = (state == IDLE);
  assign wdata_ready = (state == LOAD);
  assign req_valid   = wr_go || ((state == RD_ISSUE) && bank_avail);
  assign req_rd_wr   = req_valid && lat.rd_wr;
  assign req_wr_eos  = wr_go && last_idx;
  assign req_node_id = lat.node_id;
  assign req_pe_tag  = lat.tag;
  assign req_data    = wr_go ? line_buf[idx[AW-1:0]] : '0;
  assign rd_valid    = (state == DRAIN);
  assign rd_data     = rd_valid ? line_buf[idx[AW-1:0]] : '0;
  assign rd_last     = rd_valid && last_idx;
  assign done        = done_r;
  assign err         = err_r;

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    idx_nxt   = idx;
    tmo_nxt   = tmo_cnt;
    strm_nxt  = strm;
    done_nxt  = 1'b0;
    err_nxt   = 2'd0;
    buf_we    = 1'b0;
    buf_widx  = idx[AW-1:0];
    buf_wdat  = wdata;
    case (state)
      IDLE: if (cmd_valid) begin
        if (cmd_fv_num == 5'd0 || cmd_fv_num > 5'd16) begin
          err_nxt  = 2'd1;
          done_nxt = 1'b1;
        end else begin
          lat_nxt.rd_wr   = cmd_rd_wr;
          lat_nxt.node_id = cmd_node_id;
          lat_nxt.tag     = cmd_pe_tag;
          lat_nxt.lines   = cmd_lines;
          idx_nxt         = 5'd0;
          state_nxt       = cmd_rd_wr ? LOAD : RD_ISSUE;
        end
      end
      LOAD: if (wdata_valid) begin
        buf_we  = 1'b1;
        idx_nxt = idx + 5'd1;
        if (last_idx) begin
          idx_nxt   = 5'd0;
          state_nxt = WR_ISSUE;
        end
      end
      WR_ISSUE: if (wr_go) begin
        idx_nxt = idx + 5'd1;
        if (last_idx) begin
          idx_nxt   = 5'd0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_ISSUE: if (bank_avail) begin
        tmo_nxt   = TW'(1);
        idx_nxt   = 5'd0;
        strm_nxt  = 1'b0;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        tmo_nxt = tmo_cnt + TW'(1);
        if ((rsp_sos || rsp_eos) && rsp_tag != lat.tag) begin
          err_nxt   = 2'd3;
          strm_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (rsp_sos || rsp_eos || strm) begin
          buf_we   = (cap_idx < MAXL);
          buf_widx = cap_idx[AW-1:0];
          buf_wdat = rsp_data;
          idx_nxt  = (cap_idx == 5'd31) ? cap_idx : cap_idx + 5'd1;
          strm_nxt = 1'b1;
          if (rsp_eos) begin
            strm_nxt = 1'b0;
            idx_nxt  = 5'd0;
            if (cap_idx + 5'd1 != lat.lines) begin
              err_nxt   = 2'd3;
              state_nxt = IDLE;
            end else begin
              state_nxt = DRAIN;
            end
          end
        end
        if (!rsp_eos && state_nxt == RD_WAIT && tmo_cnt == TW'(TMO - 1)) begin
          err_nxt   = 2'd2;
          strm_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      DRAIN: if (rd_ready) begin
        idx_nxt = idx + 5'd1;
        if (last_idx) begin
          idx_nxt   = 5'd0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat     <= '0;
      idx     <= 5'd0;
      tmo_cnt <= '0;
      strm    <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 2'd0;
    end else begin
      state   <= state_nxt;
      lat     <= lat_nxt;
      idx     <= idx_nxt;
      tmo_cnt <= tmo_nxt;
      strm    <= strm_nxt;
      done_r  <= done_nxt;
      err_r   <= err_nxt;
    end
  end

  // Line storage carries no reset; contents are only read after being filled.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[buf_widx] <= buf_wdat;
  end

endmodule

// File: tb/tb_fv_bank_req_gen.sv
// Bench for fv_bank_req_gen: randomized write/read traffic against a queue-based model of expected packets and drained lines.
module tb_fv_bank_req_gen;
  localparam int FV_BW = 128, MAX_LINES = 8, NODE_W = 8, TAG_W = 2, TMO = 24;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, cmd_rd_wr;
  logic [NODE_W-1:0] cmd_node_id;
  logic [TAG_W-1:0] cmd_pe_tag;
  logic [4:0] cmd_fv_num;
  logic wdata_valid, wdata_ready, bank_avail;
  logic [FV_BW-1:0] wdata;
  logic req_valid, req_rd_wr, req_wr_eos;
  logic [NODE_W-1:0] req_node_id;
  logic [TAG_W-1:0] req_pe_tag;
  logic [FV_BW-1:0] req_data;
  logic rsp_sos, rsp_eos;
  logic [TAG_W-1:0] rsp_tag;
  logic [FV_BW-1:0] rsp_data;
  logic rd_valid, rd_ready, rd_last, done;
  logic [FV_BW-1:0] rd_data;
  logic [1:0] err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fv_bank_req_gen #(.FV_BW(FV_BW), .MAX_LINES(MAX_LINES), .NODE_W(NODE_W), .TAG_W(TAG_W), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr), .cmd_node_id(cmd_node_id),
    .cmd_pe_tag(cmd_pe_tag), .cmd_fv_num(cmd_fv_num),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .bank_avail(bank_avail),
    .req_valid(req_valid), .req_rd_wr(req_rd_wr), .req_wr_eos(req_wr_eos), .req_node_id(req_node_id),
    .req_pe_tag(req_pe_tag), .req_data(req_data),
    .rsp_sos(rsp_sos), .rsp_eos(rsp_eos), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err)
  );

  task automatic idle_inputs;
    cmd_valid = 0; cmd_rd_wr = 0; cmd_node_id = '0; cmd_pe_tag = '0; cmd_fv_num = '0;
    wdata_valid = 0; wdata = '0; bank_avail = 0;
    rsp_sos = 0; rsp_eos = 0; rsp_tag = '0; rsp_data = '0; rd_ready = 0;
  endtask

  function automatic logic [FV_BW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers one command for one cycle; returns at the next negedge with the command withdrawn.
  task automatic send_cmd(input logic wr, input logic [4:0] fv, input logic [NODE_W-1:0] node,
                          input logic [TAG_W-1:0] tag);
    @(negedge clk);
    cmd_valid = 1; cmd_rd_wr = wr; cmd_fv_num = fv; cmd_node_id = node; cmd_pe_tag = tag;
    @(negedge clk);
    cmd_valid = 0; cmd_fv_num = '0;
  endtask

  task automatic test_reset;
    reset = 1; idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cmd_ready, wdata_ready, req_valid, rd_valid, done, err} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: {cmd_ready,wdata_ready,req_valid,rd_valid,done,err}=%b expected 1000000",
               {cmd_ready, wdata_ready, req_valid, rd_valid, done, err});
    end
    checks++;
    if (req_node_id !== '0 || req_pe_tag !== '0 || req_data !== '0) begin
      errors++;
      $display("FAIL reset_fields: node=%h tag=%h data=%h expected 0", req_node_id, req_pe_tag, req_data);
    end
    @(negedge clk); reset = 0; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  // Write-back scenario; rst_at >= 0 asserts reset during that issued line.
  task automatic run_write(input int fv, input int avail_delay, input int rst_at);
    logic [FV_BW-1:0] exp_q[$];
    logic [NODE_W-1:0] node;
    int nl;
    nl = (fv + 1) / 2;
    node = NODE_W'($urandom);
    send_cmd(1'b1, 5'(fv), node, TAG_W'($urandom));
    for (int i = 0; i < nl; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wdata_valid = 0; #1;
        checks++;
        if (wdata_ready !== 1'b1 || req_valid !== 1'b0) begin
          errors++; $display("FAIL load_gap: wdata_ready=%b req_valid=%b expected 1/0", wdata_ready, req_valid);
        end
        @(negedge clk);
      end
      wdata_valid = 1; wdata = rand_line(); exp_q.push_back(wdata); #1;
      checks++;
      if (wdata_ready !== 1'b1 || req_valid !== 1'b0) begin
        errors++; $display("FAIL load_line %0d: wdata_ready=%b req_valid=%b expected 1/0", i, wdata_ready, req_valid);
      end
      @(negedge clk);
    end
    wdata_valid = 0; wdata = '0;
    for (int d = 0; d < avail_delay; d++) begin
      bank_avail = 0; #1;
      checks++;
      if (req_valid !== 1'b0) begin
        errors++; $display("FAIL wr_hold: req_valid=%b expected 0 while bank busy", req_valid);
      end
      @(negedge clk);
    end
    for (int i = 0; i < nl; i++) begin
      bank_avail = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)); #1;
      checks++;
      if ({req_valid, req_rd_wr, req_wr_eos} !== {1'b1, 1'b1, (i == nl - 1)}) begin
        errors++;
        $display("FAIL wr_pkt %0d: {valid,rd_wr,eos}=%b expected %b", i, {req_valid, req_rd_wr, req_wr_eos},
                 {1'b1, 1'b1, (i == nl - 1)});
      end
      checks++;
      if (req_data !== exp_q[i] || req_node_id !== node) begin
        errors++;
        $display("FAIL wr_data %0d: data=%h node=%h expected %h node %h", i, req_data, req_node_id, exp_q[i], node);
      end
      if (i == rst_at) begin
        reset = 1; #1;
        checks++;
        if (req_valid !== 1'b0) begin
          errors++; $display("FAIL rst_drop: req_valid=%b expected 0 right after reset", req_valid);
        end
        @(negedge clk); reset = 0; bank_avail = 0; #1;
        checks++;
        if (cmd_ready !== 1'b1 || req_valid !== 1'b0) begin
          errors++; $display("FAIL rst_recover: cmd_ready=%b req_valid=%b expected 1/0", cmd_ready, req_valid);
        end
        return;
      end
      @(negedge clk);
    end
    bank_avail = 0; #1;
    checks++;
    if ({done, req_valid, err, cmd_ready} !== 5'b10001) begin
      errors++; $display("FAIL wr_done: {done,req_valid,err,cmd_ready}=%b expected 10001", {done, req_valid, err, cmd_ready});
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL wr_done_pulse: done=%b expected 0 one cycle later", done);
    end
  endtask

  // Read scenario: nresp response lines tagged rtag; exp_err 0 means a clean drain is expected.
  task automatic run_read(input int fv, input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] rtag,
                          input int nresp, input logic [1:0] exp_err);
    logic [FV_BW-1:0] exp_q[$];
    logic [NODE_W-1:0] node;
    int nl, i, stalls;
    nl = (fv + 1) / 2;
    node = NODE_W'($urandom);
    send_cmd(1'b0, 5'(fv), node, tag);
    repeat ($urandom_range(0, 3)) begin
      bank_avail = 0; #1;
      checks++;
      if (req_valid !== 1'b0) begin
        errors++; $display("FAIL rd_hold: req_valid=%b expected 0 while bank busy", req_valid);
      end
      @(negedge clk);
    end
    bank_avail = 1; #1;
    checks++;
    if ({req_valid, req_rd_wr, req_wr_eos} !== 3'b100 || req_pe_tag !== tag || req_node_id !== node) begin
      errors++;
      $display("FAIL rd_req: {valid,rd_wr,eos}=%b tag=%0d node=%h expected 100 tag %0d node %h",
               {req_valid, req_rd_wr, req_wr_eos}, req_pe_tag, req_node_id, tag, node);
    end
    @(negedge clk); bank_avail = 0; #1;
    checks++;
    if (req_valid !== 1'b0 || req_node_id !== node) begin
      errors++; $display("FAIL rd_wait: req_valid=%b node=%h expected 0 node %h", req_valid, req_node_id, node);
    end
    repeat ($urandom_range(0, 4)) @(negedge clk);
    for (int j = 0; j < nresp; j++) begin
      @(negedge clk);
      rsp_sos = (j == 0); rsp_eos = (j == nresp - 1); rsp_tag = rtag; rsp_data = rand_line();
      exp_q.push_back(rsp_data);
    end
    @(negedge clk);
    rsp_sos = 0; rsp_eos = 0; rsp_data = '0;
    if (exp_err != 2'd0) begin
      #1;
      checks++;
      if (err !== exp_err || cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_err: err=%0d cmd_ready=%b rd_valid=%b expected err %0d ready 1 rd_valid 0",
                 err, cmd_ready, rd_valid, exp_err);
      end
      return;
    end
    i = 0; stalls = 0;
    while (i < nl) begin
      rd_ready = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1)); #1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[i] || rd_last !== (i == nl - 1) || err !== 2'd0) begin
        errors++;
        $display("FAIL drain %0d: valid=%b last=%b err=%0d data=%h expected 1 %b 0 %h",
                 i, rd_valid, rd_last, err, rd_data, (i == nl - 1), exp_q[i]);
      end
      if (rd_ready) begin i++; stalls = 0; end
      else stalls++;
      @(negedge clk);
    end
    rd_ready = 0; #1;
    checks++;
    if ({done, rd_valid, cmd_ready, err} !== 5'b10100) begin
      errors++; $display("FAIL rd_done: {done,rd_valid,cmd_ready,err}=%b expected 10100", {done, rd_valid, cmd_ready, err});
    end
  endtask

  task automatic test_write_full;   run_write(16, 0, -1); endtask
  task automatic test_write_single; run_write(1, 5, -1);  endtask
  task automatic test_read_basic;   run_read(6, 2'd2, 2'd2, 3, 2'd0); endtask

  task automatic test_timeout;
    int c;
    send_cmd(1'b0, 5'd6, NODE_W'($urandom), 2'd1);
    bank_avail = 1; #1;
    checks++;
    if (req_valid !== 1'b1) begin
      errors++; $display("FAIL tmo_issue: req_valid=%b expected 1", req_valid);
    end
    for (c = 1; c <= TMO + 4; c++) begin
      @(negedge clk); bank_avail = 0; #1;
      if (err !== 2'd0) break;
    end
    checks++;
    if (c !== TMO || err !== 2'd2 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL tmo: err=%0d after %0d cycles ready=%b expected err 2 after %0d ready 1", err, c, cmd_ready, TMO);
    end
  endtask

  task automatic test_illegal_fv;
    logic [4:0] bad[4];
    bad[0] = 5'd0; bad[1] = 5'd17; bad[2] = 5'd31; bad[3] = 5'($urandom_range(17, 31));
    for (int k = 0; k < 4; k++) begin
      send_cmd(1'($urandom_range(0, 1)), bad[k], NODE_W'($urandom), TAG_W'($urandom)); #1;
      checks++;
      if ({err, done, req_valid, cmd_ready, wdata_ready} !== 6'b011010) begin
        errors++;
        $display("FAIL illegal_fv %0d: {err,done,req_valid,cmd_ready,wdata_ready}=%b expected 011010",
                 bad[k], {err, done, req_valid, cmd_ready, wdata_ready});
      end
      @(negedge clk); #1;
      checks++;
      if (err !== 2'd0 || done !== 1'b0 || req_valid !== 1'b0) begin
        errors++; $display("FAIL illegal_pulse: err=%0d done=%b req_valid=%b expected 0/0/0", err, done, req_valid);
      end
    end
  endtask

  task automatic test_tag_mismatch;
    run_read(2, 2'd2, 2'd1, 1, 2'd3);
    run_read(6, 2'd0, 2'd0, 2, 2'd3);
  endtask

  task automatic test_rsp_ignored;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rsp_sos = 1'($urandom_range(0, 1)); rsp_eos = 1'($urandom_range(0, 1));
      rsp_tag = TAG_W'($urandom); rsp_data = rand_line(); #1;
      checks++;
      if (err !== 2'd0 || rd_valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL rsp_idle: err=%0d rd_valid=%b done=%b expected 0/0/0", err, rd_valid, done);
      end
    end
    @(negedge clk); rsp_sos = 0; rsp_eos = 0; rsp_data = '0;
  endtask

  task automatic test_back_to_back;
    logic [TAG_W-1:0] t;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) run_write($urandom_range(1, 16), $urandom_range(0, 4), -1);
      else begin
        t = TAG_W'($urandom);
        begin
          int f;
          f = $urandom_range(1, 16);
          run_read(f, t, t, (f + 1) / 2, 2'd0);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst; run_write(16, 0, 3); endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_write_full();
    test_write_single();
    test_read_basic();
    test_timeout();
    test_illegal_fv();
    test_tag_mismatch();
    test_rsp_ignored();
    test_back_to_back();
    test_reset_mid_burst();
    test_read_basic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
